tilt_sample_averager: RTL and testbench
=======================================

// Module: tilt_sample_averager
// PURPOSE
//  Sits directly upstream of the three-digit seven-segment display stage.
//  Takes signed raw tilt samples from the sensor interface and averages them over a sliding window.
//  Scales and saturates the result to an unsigned 8-bit magnitude plus a sign flag.
//  Holds the output stable for HOLD_CYCLES so the display stage's count-up conversion settles.
// PARAMETERS
//  SAMPLE_W     12    width of signed input sample (two's complement)
//  LOG2_DEPTH   3     log2 of averaging window depth (DEPTH = 8)
//  SHIFT        4     right shift applied to |average| before saturation
//  HOLD_CYCLES  5000000  display refresh period in clk cycles; must be >= 256
// PORTS
//  clk           in   1         system clock, all logic on posedge
//  rst_n         in   1         asynchronous active-low reset
//  sample_in     in   SAMPLE_W  signed raw sample, qualified by sample_valid
//  sample_valid  in   1         one-cycle strobe, sample_in accepted this cycle
//  clear         in   1         synchronous window flush
//  disp_num      out  8         held unsigned magnitude to display (0..255)
//  disp_neg      out  1         held sign of disp_num, 1 = negative
//  disp_update   out  1         one-cycle pulse when disp_num/disp_neg reload
//  avg_valid     out  1         window holds DEPTH samples since reset/clear
// BEHAVIOUR
//  Reset values:
//   - disp_num=0, disp_neg=0, disp_update=0, avg_valid=0.
//   - Sum, write pointer, fill count and hold timer all 0.
//   - Window RAM contents are not reset.
//  FSM FILLING -> RUNNING:
//   - FILLING: each accepted sample increments fill count.
//   - Move to RUNNING when the DEPTH-th sample is accepted; avg_valid rises the next cycle.
//   - RUNNING -> FILLING only on clear or reset.
//  Accepting a sample (sample_valid=1):
//   - Write sample_in to buf[wr_ptr]; wr_ptr increments modulo DEPTH.
//   - sum <= sum + sample_in - (RUNNING ? buf[wr_ptr] : 0).
//   - sum is signed, SAMPLE_W+LOG2_DEPTH bits, and never overflows.
//  Arithmetic, combinational from the registered sum:
//   - avg = sum >>> LOG2_DEPTH (arithmetic shift, rounds toward -inf).
//   - mag = |avg|, computed at SAMPLE_W+1 bits so the most-negative input is safe.
//   - scaled = mag >> SHIFT; result = (scaled > 255) ? 255 : scaled.
//   - neg = avg<0 && result!=0, so there is never a "-0".
//  Hold timer:
//   - Free-running 0..HOLD_CYCLES-1, wraps to 0.
//   - At terminal count: disp_num <= avg_valid ? result : 0, disp_neg <= avg_valid ? neg : 0, disp_update=1 for that cycle.
//   - Outputs are otherwise held unchanged.
//  Latency: sample to sum is 1 cycle; sum to display is the next timer terminal count.
//  Simultaneous events:
//   - sample_valid and terminal count in the same cycle: the latch uses the pre-update sum.
//   - clear and sample_valid in the same cycle: clear wins and the sample is dropped.
//   - clear zeroes sum, wr_ptr, fill count and avg_valid and returns the FSM to FILLING.
//   - clear leaves the disp_* outputs and the hold timer unchanged; the next update shows 0.
//  rst_n asserted mid-operation: all state and outputs go to reset values immediately, asynchronously.
// STRUCTURE
//  Shared package tilt_pkg:
//   - DISP_MAX=255 and the default SAMPLE_W.
//   - FSM state enum {FILLING, RUNNING}.
//  Sub-module refresh_tick (param HOLD_CYCLES): clk, rst_n -> one-cycle tick at terminal count.
//  Top level holds the window RAM, running sum, FSM, scale/saturate logic and output registers.
// TESTING (SAMPLE_W=12, LOG2_DEPTH=3, SHIFT=2, HOLD_CYCLES=300)
//  1 Reset: pulse rst_n low mid-run -> all outputs 0 asynchronously; avg_valid=0 until 8 new samples arrive.
//  2 Fill: 7 samples of +400 -> updates show 0; 8th sample -> next update disp_num=100, disp_neg=0.
//  3 Slide: after test 2, 4 samples of -40 -> sum=1440, avg=180, next update disp_num=45.
//  4 Saturate: 8 samples of +2047 -> 255/neg 0; 8 samples of -2048 -> 255/neg 1.
//  5 Tiny negative: 8 samples of -3 -> avg=-3, scaled=0, disp_num=0, disp_neg=0.
//  6 Clear with simultaneous sample_valid -> sample dropped, avg_valid=0, next update disp_num=0 with a disp_update pulse.

Source files
------------

// File: rtl/tilt_pkg.sv
// Shared types and constants for the tilt averaging path
// feeding the seven-segment display stage.
package tilt_pkg;

   localparam int SAMPLE_W_DEF = 12;
   localparam int DISP_W       = 8;
   localparam int DISP_MAX     = 255;

   typedef enum logic {
      FILLING = 1'b0,
      RUNNING = 1'b1
   } fill_state_e;

endpackage

// File: rtl/tilt_sample_averager_refresh_tick.sv
// Free-running display refresh timer; tick is high for the
// single cycle in which the count sits at HOLD_CYCLES-1.
module refresh_tick #(
   parameter int HOLD_CYCLES = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = $clog2(HOLD_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == CW'(HOLD_CYCLES - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tilt_sample_averager.sv
// Sliding-window tilt averager: running sum over DEPTH samples,
// scaled and saturated to 8-bit magnitude + sign, held per refresh.
module tilt_sample_averager
   import tilt_pkg::*;
#(
   parameter int SAMPLE_W    = SAMPLE_W_DEF,
   parameter int LOG2_DEPTH  = 3,
   parameter int SHIFT       = 4,
   parameter int HOLD_CYCLES = 5000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                clear,
   output logic [DISP_W-1:0]   disp_num,
   output logic                disp_neg,
   output logic                disp_update,
   output logic                avg_valid
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW    = SAMPLE_W + LOG2_DEPTH;
   localparam int MW    = SAMPLE_W + 1;

   fill_state_e             state_q;
   logic [LOG2_DEPTH-1:0]   wr_ptr_q;
   logic [LOG2_DEPTH-1:0]   fill_q;
   logic signed [SW-1:0]    sum_q;
   logic signed [SW-1:0]    sum_d;
   logic                    avg_valid_q;
   logic [SAMPLE_W-1:0]     win_q [DEPTH];

   logic [DISP_W-1:0]       disp_num_q;
   logic                    disp_neg_q;
   logic                    disp_update_q;

   logic                    tick;
   logic signed [SW-1:0]    add_s;
   logic signed [SW-1:0]    old_s;
   logic signed [SW-1:0]    avg;
   logic [MW-1:0]           avg_n;
   logic [MW-1:0]           mag;
   logic [MW-1:0]           scaled;
   logic [DISP_W-1:0]       result;
   logic                    neg;

   refresh_tick #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   always_comb begin
      add_s = {{LOG2_DEPTH{sample_in[SAMPLE_W-1]}}, sample_in};
      old_s = {{LOG2_DEPTH{win_q[wr_ptr_q][SAMPLE_W-1]}},
               win_q[wr_ptr_q]};
      sum_d = sum_q + add_s
            - ((state_q == RUNNING) ? old_s : '0);
   end

   // Average fits in SAMPLE_W bits; one extra bit keeps |-2^(W-1)| exact.
   always_comb begin
      avg    = sum_q >>> LOG2_DEPTH;
      avg_n  = avg[MW-1:0];
      mag    = avg_n[MW-1] ? (~avg_n + MW'(1)) : avg_n;
      scaled = mag >> SHIFT;
      result = (scaled > MW'(DISP_MAX)) ? DISP_W'(DISP_MAX)
                                        : scaled[DISP_W-1:0];
      neg    = avg_n[MW-1] && (result != '0);
   end

   always_ff @(posedge clk) begin
      if (sample_valid && !clear) begin
         win_q[wr_ptr_q] <= sample_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILLING;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         avg_valid_q <= 1'b0;
      end else if (clear) begin
         state_q     <= FILLING;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         sum_q       <= '0;
         avg_valid_q <= 1'b0;
      end else if (sample_valid) begin
         sum_q    <= sum_d;
         wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
         unique case (state_q)
            FILLING: begin
               fill_q <= fill_q + LOG2_DEPTH'(1);
               if (fill_q == LOG2_DEPTH'(DEPTH - 1)) begin
                  state_q     <= RUNNING;
                  avg_valid_q <= 1'b1;
               end
            end
            RUNNING: begin
               fill_q <= fill_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_num_q    <= '0;
         disp_neg_q    <= 1'b0;
         disp_update_q <= 1'b0;
      end else begin
         disp_update_q <= tick;
         if (tick) begin
            disp_num_q <= avg_valid_q ? result : '0;
            disp_neg_q <= avg_valid_q ? neg : 1'b0;
         end
      end
   end

   assign disp_num    = disp_num_q;
   assign disp_neg    = disp_neg_q;
   assign disp_update = disp_update_q;
   assign avg_valid   = avg_valid_q;

endmodule

// File: tb/tb_tilt_sample_averager.sv
// Scoreboard bench for tilt_sample_averager: each step pushes the
// expected next display value; a monitor checks on disp_update.
module tb_tilt_sample_averager;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  disp_num;
   logic        disp_neg;
   logic        disp_update;
   logic        avg_valid;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [8:0]  exp_q [$];

   tilt_sample_averager #(
      .SAMPLE_W   (12),
      .LOG2_DEPTH (3),
      .SHIFT      (2),
      .HOLD_CYCLES(300)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_in   (sample_in),
      .sample_valid(sample_valid),
      .clear       (clear),
      .disp_num    (disp_num),
      .disp_neg    (disp_neg),
      .disp_update (disp_update),
      .avg_valid   (avg_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && disp_update) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_update: got disp_num=%0d, want none",
                     disp_num);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("disp_num", int'(disp_num), int'(e[7:0]));
            chk("disp_neg", int'(disp_neg), int'(e[8]));
         end
      end
   end

   task automatic send(input int v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_in    = 12'(v);
         sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic expect_upd(input int num, input bit neg);
      exp_q.push_back({neg, 8'(num)});
   endtask

   task automatic wait_upd(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (disp_update) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: no disp_update within 400 cycles, want one",
                  name);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_num", int'(disp_num), 0);
      chk("rst_neg", int'(disp_neg), 0);
      chk("rst_upd", int'(disp_update), 0);
      chk("rst_avg_valid", int'(avg_valid), 0);
      rst_n = 1'b1;

      send(400, 7);
      chk("fill7_avg_valid", int'(avg_valid), 0);
      expect_upd(0, 0);
      wait_upd("fill7");

      send(400, 1);
      chk("fill8_avg_valid", int'(avg_valid), 1);
      expect_upd(100, 0);
      wait_upd("fill8");

      send(-40, 4);
      expect_upd(45, 0);
      wait_upd("slide");

      send(2047, 8);
      expect_upd(255, 0);
      wait_upd("sat_pos");

      send(-2048, 8);
      expect_upd(255, 1);
      wait_upd("sat_neg");

      send(-3, 8);
      expect_upd(0, 0);
      wait_upd("tiny_neg");

      send(100, 8);
      expect_upd(25, 0);
      wait_upd("pre_clear");

      @(negedge clk);
      clear        = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 12'd1000;
      @(negedge clk);
      clear        = 1'b0;
      sample_valid = 1'b0;
      chk("clear_avg_valid", int'(avg_valid), 0);
      chk("clear_holds_num", int'(disp_num), 25);
      send(400, 7);
      chk("clear_dropped", int'(avg_valid), 0);
      expect_upd(0, 0);
      wait_upd("after_clear");

      send(400, 1);
      chk("refill_avg_valid", int'(avg_valid), 1);
      expect_upd(100, 0);
      wait_upd("refill");

      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_num", int'(disp_num), 0);
      chk("async_rst_neg", int'(disp_neg), 0);
      chk("async_rst_avg_valid", int'(avg_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;

      send(800, 7);
      chk("post_rst_fill7", int'(avg_valid), 0);
      send(800, 1);
      chk("post_rst_fill8", int'(avg_valid), 1);
      expect_upd(200, 0);
      wait_upd("post_rst");

      @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
